// File: rtl/spi_regfile_slave.sv
// SPI slave exposing a bank of byte registers (read-write plus read-only) with
// selectable CPOL/CPHA, synchronised pin inputs, burst auto-increment and a write strobe.
module spi_regfile_slave #(
  parameter int RW_REG_COUNT = 23,
  parameter int RO_REG_COUNT = 1,
  parameter bit CPOL         = 1'b0,
  parameter bit CPHA         = 1'b0,
  parameter bit BURST_EN     = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      spi_cs,
  input  logic                      spi_clk,
  input  logic                      spi_mosi,
  output logic                      spi_miso,
  output logic [RW_REG_COUNT*8-1:0] rw_data,
  input  logic [RO_REG_COUNT*8-1:0] ro_data,
  output logic                      wr_strobe,
  output logic [6:0]                wr_addr
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMD  = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RD   = 2'd3;
  localparam logic [7:0] RW_LIMIT = 8'(RW_REG_COUNT);

  logic cs_meta_q, cs_sync_q, cs_prev_q;
  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic mosi_meta_q, mosi_sync_q;

  logic [1:0]                state_q, state_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic [7:0]                shift_q, shift_d;
  logic [6:0]                addr_q, addr_d;
  logic                      miso_q, miso_d;
  logic [RW_REG_COUNT*8-1:0] rw_q, rw_d;
  logic                      strobe_q, strobe_d;
  logic [6:0]                wr_addr_q, wr_addr_d;

  // Read decode over the full 7-bit address space; unmapped addresses read as all ones.
  logic [7:0] rd_table [128];
  genvar gi;
  generate
    for (gi = 0; gi < 128; gi++) begin : g_rd
      if (gi < RW_REG_COUNT) begin : g_rw
        assign rd_table[gi] = rw_q[8*gi +: 8];
      end else if (gi < RW_REG_COUNT + RO_REG_COUNT) begin : g_ro
        assign rd_table[gi] = ro_data[8*(gi-RW_REG_COUNT) +: 8];
      end else begin : g_none
        assign rd_table[gi] = 8'hFF;
      end
    end
  endgenerate

  logic       sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  logic [7:0] sample_byte;
  logic [6:0] next_addr;

  always_comb begin
    sclk_edge   = sclk_sync_q ^ sclk_prev_q;
    lead_edge   = sclk_edge && (sclk_sync_q != CPOL);
    trail_edge  = sclk_edge && (sclk_sync_q == CPOL);
    sample_edge = CPHA ? trail_edge : lead_edge;
    shift_edge  = CPHA ? lead_edge : trail_edge;
    sample_byte = {shift_q[6:0], mosi_sync_q};
    next_addr   = BURST_EN ? addr_q + 7'd1 : addr_q;

    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    miso_d    = miso_q;
    rw_d      = rw_q;
    strobe_d  = 1'b0;
    wr_addr_d = wr_addr_q;

    // A high chip select dominates every state, including a coincident 8th sample.
    if (cs_sync_q) begin
      state_d   = S_IDLE;
      bit_cnt_d = 3'd0;
      miso_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cs_prev_q) begin
            state_d   = S_CMD;
            bit_cnt_d = 3'd0;
            shift_d   = 8'h00;
          end
        end
        S_CMD: begin
          miso_d = 1'b0;
          if (sample_edge) begin
            shift_d   = sample_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              addr_d = sample_byte[6:0];
              if (sample_byte[7]) begin
                state_d = S_WR;
              end else begin
                state_d = S_RD;
                shift_d = rd_table[sample_byte[6:0]];
              end
            end
          end
        end
        S_WR: begin
          miso_d = 1'b0;
          if (sample_edge) begin
            shift_d   = sample_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if ({1'b0, addr_q} < RW_LIMIT) begin
                for (int i = 0; i < RW_REG_COUNT; i++) begin
                  if (addr_q == 7'(i)) rw_d[8*i +: 8] = sample_byte;
                end
                strobe_d  = 1'b1;
                wr_addr_d = addr_q;
              end
              addr_d = next_addr;
            end
          end
        end
        default: begin
          if (shift_edge) begin
            miso_d  = shift_q[7];
            shift_d = {shift_q[6:0], 1'b0};
          end
          if (sample_edge) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              addr_d  = next_addr;
              shift_d = rd_table[next_addr];
            end
          end
        end
      endcase
    end
  end

  // cs synchroniser resets low so a frame in flight during reset is not mistaken for a new one.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_meta_q   <= 1'b0;
      cs_sync_q   <= 1'b0;
      cs_prev_q   <= 1'b0;
      sclk_meta_q <= CPOL;
      sclk_sync_q <= CPOL;
      sclk_prev_q <= CPOL;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      addr_q      <= 7'd0;
      miso_q      <= 1'b0;
      rw_q        <= '0;
      strobe_q    <= 1'b0;
      wr_addr_q   <= 7'd0;
    end else begin
      cs_meta_q   <= spi_cs;
      cs_sync_q   <= cs_meta_q;
      cs_prev_q   <= cs_sync_q;
      sclk_meta_q <= spi_clk;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      mosi_meta_q <= spi_mosi;
      mosi_sync_q <= mosi_meta_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      miso_q      <= miso_d;
      rw_q        <= rw_d;
      strobe_q    <= strobe_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  assign spi_miso  = miso_q;
  assign rw_data   = rw_q;
  assign wr_strobe = strobe_q;
  assign wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_spi_regfile_slave.sv
// Directed bench: a mode-0 and a mode-3 slave driven by a behavioural SPI master,
// checked against hand-computed register contents, read bytes and strobe logs.
module tb_spi_regfile_slave;
  localparam int  RW   = 23;
  localparam int  W    = RW * 8;
  localparam time HALF = 80ns;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cs0 = 1'b1, cs3 = 1'b1;
  logic         sclk0 = 1'b0, sclk3 = 1'b1;
  logic         mosi = 1'b0;
  logic         miso0, miso3;
  logic [W-1:0] rw0, rw3;
  logic [7:0]   ro0 = 8'h00;
  logic [7:0]   ro3 = 8'h00;
  logic         stb0, stb3;
  logic [6:0]   wa0, wa3;

  always #5ns clk = ~clk;

  spi_regfile_slave #(.RW_REG_COUNT(RW), .RO_REG_COUNT(1), .CPOL(1'b0), .CPHA(1'b0), .BURST_EN(1'b1)) u_mode0 (
    .clk(clk), .rst(rst), .spi_cs(cs0), .spi_clk(sclk0), .spi_mosi(mosi), .spi_miso(miso0),
    .rw_data(rw0), .ro_data(ro0), .wr_strobe(stb0), .wr_addr(wa0));

  spi_regfile_slave #(.RW_REG_COUNT(RW), .RO_REG_COUNT(1), .CPOL(1'b1), .CPHA(1'b1), .BURST_EN(1'b1)) u_mode3 (
    .clk(clk), .rst(rst), .spi_cs(cs3), .spi_clk(sclk3), .spi_mosi(mosi), .spi_miso(miso3),
    .rw_data(rw3), .ro_data(ro3), .wr_strobe(stb3), .wr_addr(wa3));

  // Strobe monitors: rising-edge count, high-cycle count and address logged per pulse.
  int         pulses0 = 0, hi0 = 0, pulses3 = 0, hi3 = 0;
  logic       prev0 = 1'b0, prev3 = 1'b0;
  logic [6:0] log0 [64];
  logic [6:0] log3 [64];

  always @(negedge clk) begin
    prev0 <= stb0;
    prev3 <= stb3;
    if (stb0) begin
      hi0 <= hi0 + 1;
      if (!prev0) begin
        log0[pulses0 % 64] <= wa0;
        pulses0 <= pulses0 + 1;
      end
    end
    if (stb3) begin
      hi3 <= hi3 + 1;
      if (!prev3) begin
        log3[pulses3 % 64] <= wa3;
        pulses3 <= pulses3 + 1;
      end
    end
  end

  int         vectors = 0;
  int         errors  = 0;
  logic [7:0] exp0 [RW];
  logic [7:0] exp3 [RW];
  logic [7:0] tx_buf [8];
  logic [7:0] rx_buf [8];
  int         p0_base, h0_base, p3_base, h3_base;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, expv);
    end
  endtask

  task automatic checkv(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] pack(input int m);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < RW; i++) v[8*i +: 8] = (m == 0) ? exp0[i] : exp3[i];
    return v;
  endfunction

  task automatic xfer(input int m, input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int b = 7; b > 7 - nbits; b--) begin
      if (m == 0) begin
        mosi = tx[b]; #HALF; rx[b] = miso0; sclk0 = 1'b1; #HALF; sclk0 = 1'b0;
      end else begin
        sclk3 = 1'b0; mosi = tx[b]; #HALF; rx[b] = miso3; sclk3 = 1'b1; #HALF;
      end
    end
  endtask

  task automatic set_cs(input int m, input logic v);
    if (m == 0) cs0 = v; else cs3 = v;
  endtask

  task automatic frame(input int m, input int n);
    logic [7:0] r;
    p0_base = pulses0; h0_base = hi0; p3_base = pulses3; h3_base = hi3;
    set_cs(m, 1'b0);
    #HALF;
    for (int k = 0; k < n; k++) begin
      xfer(m, tx_buf[k], 8, r);
      rx_buf[k] = r;
    end
    #HALF;
    set_cs(m, 1'b1);
    #200ns;
    $display("frame mode%0d cmd=%02h bytes=%0d rx1=%02h rx2=%02h", (m == 0) ? 0 : 3,
             tx_buf[0], n, rx_buf[1], rx_buf[2]);
  endtask

  initial begin
    logic [7:0] r;
    for (int i = 0; i < RW; i++) begin exp0[i] = 8'h00; exp3[i] = 8'h00; end
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    #100ns;

    checkv("reset_rw0", rw0, '0);
    checkv("reset_rw3", rw3, '0);
    check8("reset_miso", {6'd0, miso3, miso0}, 8'h00);
    check8("reset_strobe", {6'd0, stb3, stb0}, 8'h00);
    check8("reset_wr_addr", {1'b0, wa0 | wa3}, 8'h00);

    // Single write to address 5.
    tx_buf[0] = 8'h85; tx_buf[1] = 8'h3C;
    frame(0, 2);
    exp0[5] = 8'h3C;
    checkv("wr5_rw", rw0, pack(0));
    checki("wr5_pulses", pulses0 - p0_base, 1);
    checki("wr5_width", hi0 - h0_base, 1);
    check8("wr5_addr", {1'b0, log0[p0_base % 64]}, 8'h05);
    check8("wr5_cmd_miso", rx_buf[0], 8'h00);

    // Burst write from address 0.
    tx_buf[0] = 8'h80; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22; tx_buf[3] = 8'h33;
    frame(0, 4);
    exp0[0] = 8'h11; exp0[1] = 8'h22; exp0[2] = 8'h33;
    checkv("burst_rw", rw0, pack(0));
    checki("burst_pulses", pulses0 - p0_base, 3);
    checki("burst_width", hi0 - h0_base, 3);
    check8("burst_addr0", {1'b0, log0[p0_base % 64]}, 8'h00);
    check8("burst_addr1", {1'b0, log0[(p0_base + 1) % 64]}, 8'h01);
    check8("burst_addr2", {1'b0, log0[(p0_base + 2) % 64]}, 8'h02);

    // Read the read-only register, then burst past the end of the map.
    ro0 = 8'h5A;
    tx_buf[0] = 8'h17; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    frame(0, 3);
    check8("ro_read", rx_buf[1], 8'h5A);
    check8("oor_read", rx_buf[2], 8'hFF);
    check8("ro_cmd_miso", rx_buf[0], 8'h00);

    // Read the top address, then wrap to address 0.
    tx_buf[0] = 8'h7F; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    frame(0, 3);
    check8("top_read", rx_buf[1], 8'hFF);
    check8("wrap_read", rx_buf[2], 8'h11);

    // Write at address 127 is discarded; the burst wraps and writes address 0.
    tx_buf[0] = 8'hFF; tx_buf[1] = 8'hEE; tx_buf[2] = 8'h44;
    frame(0, 3);
    exp0[0] = 8'h44;
    checkv("wrapwr_rw", rw0, pack(0));
    checki("wrapwr_pulses", pulses0 - p0_base, 1);
    check8("wrapwr_addr", {1'b0, log0[p0_base % 64]}, 8'h00);

    // Write to the read-only address has no effect.
    tx_buf[0] = 8'h97; tx_buf[1] = 8'h12;
    frame(0, 2);
    checkv("rowr_rw", rw0, pack(0));
    checki("rowr_pulses", pulses0 - p0_base, 0);

    // cs raised after four data bits: partial byte dropped.
    p0_base = pulses0;
    cs0 = 1'b0; #HALF;
    xfer(0, 8'h81, 8, r);
    xfer(0, 8'hF0, 4, r);
    cs0 = 1'b1; #200ns;
    $display("frame mode0 cmd=81 partial data, 4 bits then cs high");
    checkv("abort_rw", rw0, pack(0));
    checki("abort_pulses", pulses0 - p0_base, 0);
    check8("abort_miso", {7'd0, miso0}, 8'h00);
    tx_buf[0] = 8'h81; tx_buf[1] = 8'h77;
    frame(0, 2);
    exp0[1] = 8'h77;
    checkv("after_abort_rw", rw0, pack(0));
    checki("after_abort_pulses", pulses0 - p0_base, 1);
    check8("after_abort_addr", {1'b0, log0[p0_base % 64]}, 8'h01);

    // Mode 3: burst write then read back.
    tx_buf[0] = 8'h82; tx_buf[1] = 8'hA5; tx_buf[2] = 8'hC3;
    frame(3, 3);
    exp3[2] = 8'hA5; exp3[3] = 8'hC3;
    checkv("m3_wr_rw", rw3, pack(3));
    checki("m3_wr_pulses", pulses3 - p3_base, 2);
    checki("m3_wr_width", hi3 - h3_base, 2);
    check8("m3_wr_addr0", {1'b0, log3[p3_base % 64]}, 8'h02);
    check8("m3_wr_addr1", {1'b0, log3[(p3_base + 1) % 64]}, 8'h03);
    tx_buf[0] = 8'h02; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    frame(3, 3);
    check8("m3_cmd_miso", rx_buf[0], 8'h00);
    check8("m3_rd0", rx_buf[1], 8'hA5);
    check8("m3_rd1", rx_buf[2], 8'hC3);

    // Reset in the middle of a burst after one committed byte.
    p0_base = pulses0;
    cs0 = 1'b0; #HALF;
    xfer(0, 8'h80, 8, r);
    xfer(0, 8'h99, 8, r);
    xfer(0, 8'h5F, 4, r);
    #HALF;
    exp0[0] = 8'h99;
    checkv("pre_rst_rw", rw0, pack(0));
    checki("pre_rst_pulses", pulses0 - p0_base, 1);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #20ns;
    $display("reset asserted mid-burst on mode0 frame");
    for (int i = 0; i < RW; i++) begin exp0[i] = 8'h00; exp3[i] = 8'h00; end
    checkv("rst_rw0", rw0, '0);
    checkv("rst_rw3", rw3, '0);
    check8("rst_strobe_addr", {stb0, wa0}, 8'h00);
    check8("rst_miso", {7'd0, miso0}, 8'h00);
    p0_base = pulses0;
    xfer(0, 8'h50, 4, r);
    xfer(0, 8'h55, 8, r);
    #HALF;
    cs0 = 1'b1; #200ns;
    checkv("abandoned_rw", rw0, '0);
    checki("abandoned_pulses", pulses0 - p0_base, 0);
    tx_buf[0] = 8'h84; tx_buf[1] = 8'h66;
    frame(0, 2);
    exp0[4] = 8'h66;
    checkv("post_rst_rw", rw0, pack(0));
    checki("post_rst_pulses", pulses0 - p0_base, 1);
    check8("post_rst_addr", {1'b0, log0[p0_base % 64]}, 8'h04);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/spi_regfile_slave.md
Name: spi_regfile_slave

Overview:
- Parametrised successor to the team's mode-0 SPI register slave.
- Exposes RW_REG_COUNT read-write and RO_REG_COUNT read-only byte registers to an external SPI master. Adds selectable SPI mode (CPOL/CPHA), input synchronisers, burst transfers with address auto-increment, and a per-byte write strobe.
- Sits between the chip's SPI pins and the design's configuration/status registers.

Parameters:
- RW_REG_COUNT, 23, number of read-write byte registers, addresses 0..RW_REG_COUNT-1.
- RO_REG_COUNT, 1, number of read-only byte registers, addresses RW_REG_COUNT..RW_REG_COUNT+RO_REG_COUNT-1. RW_REG_COUNT+RO_REG_COUNT must be <= 128.
- CPOL, 0, idle level of spi_clk.
- CPHA, 0, 0 = sample on leading edge / shift on trailing edge; 1 = shift on leading edge / sample on trailing edge.
- BURST_EN, 1, 1 = address auto-increments after each data byte; 0 = address held for the whole frame.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- spi_cs  input  1  chip select, active low, asynchronous to clk
- spi_clk  input  1  SPI clock, asynchronous to clk
- spi_mosi  input  1  master-out data, asynchronous to clk
- spi_miso  output  1  master-in data
- rw_data  output  RW_REG_COUNT*8  flattened RW registers; byte i is at [8*i+7:8*i]
- ro_data  input  RO_REG_COUNT*8  flattened RO registers; byte j is at address RW_REG_COUNT+j
- wr_strobe  output  1  one-clk pulse when an RW byte is committed
- wr_addr  output  7  address of the last committed write

Behaviour:
- Clocking and reset:
  - Single clock domain (clk). Reset is synchronous and active-high.
  - On rst: rw_data=0, spi_miso=0, wr_strobe=0, wr_addr=0, FSM=IDLE, bit counter=0, shift register=0.
- Input synchronisation:
  - spi_cs, spi_clk and spi_mosi each pass through a 2-flop synchroniser.
  - Edges are detected on the synchronised spi_clk against a registered previous value.
  - Supported when the spi_clk frequency is <= clk/8.
  - Leading edge = transition away from CPOL; trailing edge = transition back to CPOL.
- Frame format:
  - The frame starts with a command byte, MSB first.
  - Command bit7: 1 = write, 0 = read. Command bits[6:0] = start address.
  - The command byte is followed by zero or more data bytes, MSB first.
- FSM states: IDLE, CMD, WR, RD.
  - IDLE -> CMD when synchronised cs falls; the bit counter clears.
  - CMD: shifts in 8 bits on sample edges. On the 8th sample, latch the address and go to WR (bit7=1) or RD (bit7=0).
  - On entry to RD, load the read byte into the shift register:
    - address < RW_REG_COUNT: the rw_data byte;
    - address < RW_REG_COUNT+RO_REG_COUNT: the ro_data byte;
    - otherwise: 8'hFF.
  - WR: shifts in 8 bits. On the 8th sample:
    - if address < RW_REG_COUNT: write the byte to rw_data, pulse wr_strobe for exactly one clk, set wr_addr=address;
    - otherwise: discard the byte, no strobe.
    - Then, if BURST_EN, address = address+1 modulo 128. The counter wraps and stays in WR.
  - RD:
    - spi_miso drives shift-register bit7 on each shift edge, then the register shifts left.
    - After the 8th sample edge of each byte, the address increments (if BURST_EN) and the next byte is reloaded using the same address decode.
    - Data is captured at the reload instant.
  - CPHA=0 first bit: MSB appears on the trailing edge that follows the command byte's 8th (leading-edge) sample.
  - CPHA=1: each bit appears on the leading edge of its own bit period.
  - Any state -> IDLE when synchronised cs is high.
- cs deasserted mid-byte:
  - The partial byte is discarded, with no write and no strobe.
  - The bit counter clears and spi_miso = 0.
  - Bytes already committed stay committed.
- spi_miso is held 0 while cs is high and during CMD and WR.
- Reset asserted mid-frame: full reset as above. The frame is abandoned until the next cs falling edge.
- Simultaneous events:
  - cs rise in the same cycle as the 8th sample edge: cs wins and the byte is discarded.
  - rst overrides everything.
- Writes to RO addresses and out-of-range addresses have no effect. Reads of out-of-range addresses return 8'hFF.

Test Plan:
- Mode 0, write frame 0x85,0x3C -> rw_data byte 5 = 0x3C; wr_strobe high for exactly 1 clk with wr_addr=5; other bytes unchanged.
- Mode 0, burst write 0x80,0x11,0x22,0x33 -> bytes 0/1/2 = 0x11/0x22/0x33; three wr_strobe pulses with wr_addr 0,1,2.
- Mode 3 (CPOL=1, CPHA=1), after writing 0xA5 to address 2, read frame 0x02 + 2 dummy bytes -> miso returns 0xA5, then byte 3's value.
- Read at RW_REG_COUNT with ro_data=0x5A, then burst into the next address -> 0x5A, then 0xFF (out of range).
- Write 0x81, then raise cs after 4 data bits -> byte 1 unchanged, no strobe; the next frame 0x81,0x77 writes 0x77.
- Assert rst mid-burst after 1 committed byte -> all rw_data = 0, wr_strobe = 0, FSM in IDLE; a new frame then works normally.
